// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//
// Fills the 16-bit instruction register from byte-wide memory with two reads:
// low byte from address PC, then high byte from PC+1. Owns the program
// counter, drives the IR write-enable and byte-select, and pulses InstrValid
// once the full instruction has been latched.
//
// Ports:
//   Clock       in   system clock, rising-edge
//   Reset       in   synchronous, active-high
//   Start       in   fetch request, sampled only in IDLE
//   PCLoad      in   load PC from PCIn, honoured only in IDLE
//   PCIn        in   [15:0] new PC value
//   MemAck      in   byte bus data valid this cycle
//   MemRead     out  memory read request
//   Address     out  [15:0] memory byte address (always equals PC)
//   PC          out  [15:0] program counter
//   IRWrite     out  IR write enable (MemRead & MemAck, combinational)
//   IRLH        out  IR byte select: 0 = bits [7:0], 1 = bits [15:8]
//   InstrValid  out  one-cycle pulse, complete instruction is in the IR
//   Busy        out  high in every state except IDLE
//   Fault       out  sticky memory-timeout flag
//
// Build option: FETCH_TIMEOUT_EN adds a per-byte wait counter and a FAULT
// state entered after TIMEOUT_CYCLES unacknowledged request cycles. Without
// it the request states wait for MemAck forever and Fault is tied low.
//
// state  | meaning
// IDLE   | waiting for Start; PCLoad accepted here only
// REQ_LO | reading low byte from PC
// REQ_HI | reading high byte from PC (already advanced by one)
// DONE   | instruction complete, InstrValid high for this cycle
// FAULT  | memory timeout, held until Reset (FETCH_TIMEOUT_EN only)

module instruction_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        PCLoad,
  input  logic [15:0] PCIn,
  input  logic        MemAck,
  output logic        MemRead,
  output logic [15:0] Address,
  output logic [15:0] PC,
  output logic        IRWrite,
  output logic        IRLH,
  output logic        InstrValid,
  output logic        Busy,
  output logic        Fault
);

  // The wait counter is 4 bits wide, so the timeout must fit in 1..16.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in the range 1..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    REQ_HI,
    DONE
`ifdef FETCH_TIMEOUT_EN
    ,
    FAULT
`endif
  } state_t;

  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] wait_cnt;
`else
  assign Fault = 1'b0;
`endif

  assign Address = PC;
  // Same-edge capture: the IR latches the byte bus on the edge the ack is seen.
  assign IRWrite = MemRead & MemAck;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= 16'h0000;
      MemRead    <= 1'b0;
      IRLH       <= 1'b0;
      InstrValid <= 1'b0;
      Busy       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= 4'd0;
      Fault      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Load and Start on the same edge: the fetch uses the new PC.
          if (PCLoad) PC <= PCIn;
          if (Start) begin
            state   <= REQ_LO;
            MemRead <= 1'b1;
            IRLH    <= 1'b0;
            Busy    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= 4'd0;
`endif
          end
        end

        REQ_LO, REQ_HI: begin
          if (MemAck) begin
            // An ack on the terminal wait cycle still completes the byte.
            PC <= PC + 16'd1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= 4'd0;
`endif
            if (state == REQ_LO) begin
              state <= REQ_HI;
              IRLH  <= 1'b1;
            end else begin
              state      <= DONE;
              MemRead    <= 1'b0;
              IRLH       <= 1'b0;
              InstrValid <= 1'b1;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            state   <= FAULT;
            MemRead <= 1'b0;
            IRLH    <= 1'b0;
            Fault   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end

        DONE: begin
          state      <= IDLE;
          InstrValid <= 1'b0;
          Busy       <= 1'b0;
        end

`ifdef FETCH_TIMEOUT_EN
        FAULT: begin
          // Sticky: PC frozen, Busy and Fault held until Reset.
        end
`endif

        default: begin
          state      <= IDLE;
          MemRead    <= 1'b0;
          IRLH       <= 1'b0;
          InstrValid <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        PCLoad = 1'b0;
  logic [15:0] PCIn = 16'h0000;
  logic        MemAck = 1'b0;
  logic        MemRead;
  logic [15:0] Address;
  logic [15:0] PC;
  logic        IRWrite;
  logic        IRLH;
  logic        InstrValid;
  logic        Busy;
  logic        Fault;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemAck(MemAck), .MemRead(MemRead), .Address(Address), .PC(PC),
    .IRWrite(IRWrite), .IRLH(IRLH), .InstrValid(InstrValid), .Busy(Busy),
    .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  // {rst, st, ld, ack} inputs; expected {MemRead, IRWrite, IRLH, InstrValid, Busy}
  typedef struct {
    logic [3:0]  in;
    logic [15:0] pi;
    bit          chk;
    logic [4:0]  ex;
    logic [15:0] pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] in, input logic [15:0] pi, input bit chk,
                     input logic [4:0] ex, input logic [15:0] pc);
    vec_t v;
    v.in = in; v.pi = pi; v.chk = chk; v.ex = ex; v.pc = pc;
    vq.push_back(v);
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 ns later,
  // well away from the next rising edge.
  task automatic drive(input logic rst, input logic st, input logic ld,
                       input logic [15:0] pi, input logic ack);
    @(negedge Clock);
    Reset = rst; Start = st; PCLoad = ld; PCIn = pi; MemAck = ack;
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random fetch episodes against a transaction-level model: only the model PC
  // is carried; per-cycle expectations come from the wait counts chosen.
  logic [15:0] m_pc;

  task automatic random_episode();
    logic        ld;
    logic [15:0] pi, p, p1;
    int          wl, wh, last, n_idle;
    logic        ack, exp_irw;
    n_idle = int'($urandom_range(0, 2));
    for (int k = 0; k < n_idle; k++) begin
      ld = 1'($urandom_range(0, 1));
      pi = 16'($urandom);
      drive(1'b0, 1'b0, ld, pi, 1'($urandom_range(0, 1)));
      check1("rnd_idle_busy", Busy, 1'b0);
      check1("rnd_idle_irwrite", IRWrite, 1'b0);
      check16("rnd_idle_pc", PC, m_pc);
      if (ld) m_pc = pi;
    end
    ld = 1'($urandom_range(0, 1));
    pi = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    wl = int'($urandom_range(0, 5));
    wh = int'($urandom_range(0, 5));
    p  = ld ? pi : m_pc;
    p1 = p + 16'd1;
    last = wl + wh + 3;
    drive(1'b0, 1'b1, ld, pi, 1'($urandom_range(0, 1)));
    check1("rnd_start_busy", Busy, 1'b0);
    check16("rnd_start_pc", PC, m_pc);
    for (int c = 1; c <= last; c++) begin
      if (c == wl + 1 || c == wl + wh + 2) ack = 1'b1;
      else if (c == last) ack = 1'($urandom_range(0, 1));
      else ack = 1'b0;
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), ack);
      exp_irw = (c == wl + 1) || (c == wl + wh + 2);
      check1("rnd_irwrite", IRWrite, exp_irw);
      if (exp_irw) begin
        check16("rnd_addr", Address, (c == wl + 1) ? p : p1);
        check1("rnd_irlh", IRLH, (c != wl + 1));
      end
      check1("rnd_valid", InstrValid, (c == last));
      check1("rnd_busy", Busy, 1'b1);
      check1("rnd_memread", MemRead, (c < last));
    end
    m_pc = p + 16'd2;
  endtask

  initial begin
    int valid_at, irw_cnt, fault_at;

    // Directed cycle table: reset, minimal fetch, PCLoad+Start, wrap, reset in REQ_HI.
    add(4'b1000, 16'h0000, 1'b0, 5'b00000, 16'h0000);
    add(4'b0001, 16'h0000, 1'b1, 5'b00000, 16'h0000);
    add(4'b0101, 16'h0000, 1'b1, 5'b00000, 16'h0000);
    add(4'b0001, 16'h0000, 1'b1, 5'b11001, 16'h0000);
    add(4'b0001, 16'h0000, 1'b1, 5'b11101, 16'h0001);
    add(4'b0001, 16'h0000, 1'b1, 5'b00011, 16'h0002);
    add(4'b0111, 16'h1234, 1'b1, 5'b00000, 16'h0002);
    add(4'b0011, 16'hAAAA, 1'b1, 5'b11001, 16'h1234);
    add(4'b0101, 16'h0000, 1'b1, 5'b11101, 16'h1235);
    add(4'b0101, 16'h0000, 1'b1, 5'b00011, 16'h1236);
    add(4'b0001, 16'h0000, 1'b1, 5'b00000, 16'h1236);
    add(4'b0110, 16'hFFFF, 1'b1, 5'b00000, 16'h1236);
    add(4'b0000, 16'h0000, 1'b1, 5'b10001, 16'hFFFF);
    add(4'b0001, 16'h0000, 1'b1, 5'b11001, 16'hFFFF);
    add(4'b0001, 16'h0000, 1'b1, 5'b11101, 16'h0000);
    add(4'b0000, 16'h0000, 1'b1, 5'b00011, 16'h0001);
    add(4'b0001, 16'h0000, 1'b1, 5'b00000, 16'h0001);
    add(4'b0010, 16'h00F0, 1'b1, 5'b00000, 16'h0001);
    add(4'b0100, 16'h0000, 1'b1, 5'b00000, 16'h00F0);
    add(4'b0001, 16'h0000, 1'b1, 5'b11001, 16'h00F0);
    add(4'b0000, 16'h0000, 1'b1, 5'b10101, 16'h00F1);
    add(4'b1000, 16'h0000, 1'b1, 5'b10101, 16'h00F1);
    add(4'b0000, 16'h0000, 1'b1, 5'b00000, 16'h0000);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in[3], vq[i].in[2], vq[i].in[1], vq[i].pi, vq[i].in[0]);
      if (vq[i].chk) begin
        check1("tbl_memread", MemRead, vq[i].ex[4]);
        check1("tbl_irwrite", IRWrite, vq[i].ex[3]);
        check1("tbl_irlh", IRLH, vq[i].ex[2]);
        check1("tbl_valid", InstrValid, vq[i].ex[1]);
        check1("tbl_busy", Busy, vq[i].ex[0]);
        check16("tbl_pc", PC, vq[i].pc);
        check16("tbl_addr", Address, vq[i].pc);
        check1("tbl_fault", Fault, 1'b0);
      end
    end

    // Wait states: 3 in REQ_LO, 2 in REQ_HI -> InstrValid 8 cycles after Start.
    valid_at = -1; irw_cnt = 0;
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, (c == 4 || c == 7));
      if (IRWrite) begin
        irw_cnt++;
        check16("wait_addr", Address, (c == 4) ? 16'h0000 : 16'h0001);
        check1("wait_irlh", IRLH, (c == 7));
      end
      if (InstrValid && valid_at < 0) valid_at = c;
    end
    check_int("wait_valid_cycle", valid_at, 8);
    check_int("wait_irwrite_count", irw_cnt, 2);
    check16("wait_final_pc", PC, 16'h0002);
    check1("wait_idle_busy", Busy, 1'b0);

    // MemAck stuck low.
    fault_at = -1;
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      if (c == 15) check1("stuck_memread_c15", MemRead, 1'b1);
      if (Fault === 1'b1 && fault_at < 0) fault_at = c;
    end
`ifdef FETCH_TIMEOUT_EN
    check_int("fault_cycle", fault_at, 16);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);
      check1("fault_sticky", Fault, 1'b1);
      check1("fault_busy", Busy, 1'b1);
      check1("fault_memread", MemRead, 1'b0);
      check16("fault_pc", PC, 16'h0002);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check1("fault_cleared", Fault, 1'b0);
    check1("fault_reset_busy", Busy, 1'b0);
    check16("fault_reset_pc", PC, 16'h0000);
    // Ack on the 15th REQ_LO cycle beats the timeout.
    fault_at = -1; valid_at = -1;
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, (c == 15 || c == 16));
      if (Fault === 1'b1 && fault_at < 0) fault_at = c;
      if (InstrValid && valid_at < 0) valid_at = c;
    end
    check_int("late_ack_no_fault", fault_at, -1);
    check_int("late_ack_valid_cycle", valid_at, 17);
    check16("late_ack_pc", PC, 16'h0002);
`else
    check_int("no_fault_when_disabled", fault_at, -1);
    check1("still_waiting_memread", MemRead, 1'b1);
    valid_at = -1;
    for (int c = 21; c <= 24; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, (c == 21 || c == 22));
      if (InstrValid && valid_at < 0) valid_at = c;
    end
    check_int("late_ack_valid_cycle", valid_at, 23);
    check16("late_ack_pc", PC, 16'h0004);
`endif

    // Randomized episodes from a known reset state.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    m_pc = 16'h0000;
    for (int e = 0; e < 40; e++) random_episode();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

- Sequences the two byte reads that fill the 16-bit instruction register from byte-wide memory: low byte first (address PC), then high byte (address PC+1).
- Owns the program counter and drives the instruction register's write-enable and low/high byte-select.
- Pulses InstrValid to the decoder once the full instruction is latched.
- Sits between the control unit (Start, PC load) and the memory/instruction-register pair.

## Interface
- TIMEOUT_CYCLES, 15: number of consecutive unacknowledged request cycles that raises Fault. Used only with FETCH_TIMEOUT_EN.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  fetch request; sampled only in IDLE.
- PCLoad  in  1  load PC from PCIn; honoured only in IDLE.
- PCIn  in  16  new PC value.
- MemAck  in  1  memory data on the byte bus is valid this cycle.
- MemRead  out  1  memory read request.
- Address  out  16  memory byte address; always equals PC.
- PC  out  16  current program counter.
- IRWrite  out  1  instruction register write enable.
- IRLH  out  1  instruction register byte select: 0 = bits [7:0], 1 = bits [15:8].
- InstrValid  out  1  one-cycle pulse; the complete instruction is in the IR.
- Busy  out  1  high in every state except IDLE.
- Fault  out  1  sticky memory-timeout flag.

## Operation
States: IDLE, REQ_LO, REQ_HI, DONE, FAULT.

- **Reset:** state = IDLE, PC = 16'h0000, timeout counter = 0. All outputs are 0; Address = 0.
- **IDLE:**
  - PCLoad=1 → PC <= PCIn.
  - Start=1 → REQ_LO.
  - Start and PCLoad together → PC loads and the state moves to REQ_LO on the same edge, so the fetch uses PCIn.
- **REQ_LO:**
  - MemRead=1, IRLH=0, IRWrite=MemAck (combinational).
  - On MemAck: PC <= PC+1, go to REQ_HI.
  - No MemAck: stay in REQ_LO.
- **REQ_HI:** identical to REQ_LO with IRLH=1; on MemAck go to DONE.
- **DONE:** InstrValid=1 for exactly this cycle, then IDLE. Start is ignored in DONE.
- **PC arithmetic:** 16-bit modulo; 16'hFFFF+1 = 16'h0000. The high byte of an instruction at 16'hFFFF is read from 16'h0000.
- **PCLoad outside IDLE:** ignored, with no effect on PC.
- **Start outside IDLE:** ignored; it is not queued.
- **Reset mid-fetch:** returns to IDLE with PC=0 in the next cycle. The partially written IR is not cleared; InstrValid is not pulsed.
- **MemAck outside REQ states:** ignored.

## Timing
- MemRead, IRLH, Busy and InstrValid are Moore outputs, registered-state decoded.
- IRWrite is MemRead AND MemAck, combinational, so the IR captures the byte bus on the same edge the ack is seen.
- Minimum fetch, with MemAck held high: Start sampled at edge 0 → REQ_LO in cycle 1 → REQ_HI in cycle 2 → DONE in cycle 3 (InstrValid=1) → IDLE in cycle 4.
- Back-to-back fetch period is therefore 4 cycles.
- Each extra wait cycle (MemAck=0) adds one cycle to the corresponding REQ state.
- Address changes one cycle after the ack edge; the memory must present data for the new address no earlier than the next ack.

## Configuration
- **FETCH_TIMEOUT_EN defined:**
  - A 4-bit wait counter clears on entry to each REQ state and increments every REQ cycle with MemAck=0.
  - If MemAck=0 while the counter equals TIMEOUT_CYCLES-1, the next state is FAULT. MemAck on that same cycle takes priority and completes the byte normally.
  - FAULT: Fault=1, Busy=1, MemRead=0, PC frozen. Only Reset exits FAULT.
- **FETCH_TIMEOUT_EN undefined:**
  - No counter and no FAULT state; Fault is tied to 0.
  - REQ states wait for MemAck indefinitely.

## Test plan
- Reset, then Start with MemAck=1 constant → IRWrite with IRLH=0 in cycle 1 (Address 0000), IRWrite with IRLH=1 in cycle 2 (Address 0001), InstrValid in cycle 3, PC=0002.
- PCLoad=1 with PCIn=16'h1234 and Start=1 in the same IDLE cycle → addresses 1234 then 1235; final PC=1236.
- PCIn=16'hFFFF, fetch → Address FFFF then 0000; final PC=0001.
- MemAck low for 3 cycles in REQ_LO and 2 cycles in REQ_HI → InstrValid 8 cycles after Start; IRWrite asserted exactly twice.
- Reset asserted in REQ_HI → next cycle IDLE, PC=0000, Busy=0, no InstrValid.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=15, MemAck stuck low → Fault=1 after 15 REQ_LO cycles, held until Reset. With MemAck arriving on cycle 15 instead → no fault and the fetch proceeds.
